// File: rtl/decoder_scan_sequencer.sv
// Drives 2-to-4 decoder selects through the enabled lines with a programmable dwell per line and enable blanking between lines.
// All outputs are registered and valid one cycle after the deciding edge; there is no backpressure, and stop aborts to IDLE on the next edge.
module decoder_scan_sequencer #(
    parameter int DWELL_W      = 8,
    parameter int BLANK_CYCLES = 1,
    parameter bit EN_ACT_HIGH  = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               mode_cont_i,
    input  logic [DWELL_W-1:0] dwell_i,
    input  logic [3:0]         line_mask_i,
    output logic               sel_a_o,
    output logic               sel_b_o,
    output logic               dec_en_o,
    output logic               busy_o,
    output logic               line_done_o,
    output logic               scan_done_o
);

    typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_t;

    localparam int            BW     = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BW-1:0] BLAST  = (BLANK_CYCLES > 1) ? BW'(BLANK_CYCLES - 1) : '0;
    localparam logic          EN_ON  = EN_ACT_HIGH;
    localparam logic          EN_OFF = !EN_ACT_HIGH;

    function automatic logic [1:0] lowest(input logic [3:0] m);
        lowest = 2'd0;
        for (int j = 3; j >= 0; j--) begin
            if (m[j]) lowest = 2'(j);
        end
    endfunction

    function automatic logic has_above(input logic [3:0] m, input logic [1:0] i);
        has_above = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (m[j] && (j > int'(i))) has_above = 1'b1;
        end
    endfunction

    function automatic logic [1:0] next_above(input logic [3:0] m, input logic [1:0] i);
        next_above = i;
        for (int j = 3; j >= 0; j--) begin
            if (m[j] && (j > int'(i))) next_above = 2'(j);
        end
    endfunction

    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [BW-1:0]      bcnt_q, bcnt_d;
    logic [3:0]         mask_q, mask_d;
    logic [1:0]         sel_q, sel_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               ld_q, ld_d;
    logic               sd_q, sd_d;
    logic               adv, go_idle, last_cycle;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        bcnt_d  = bcnt_q;
        dwell_d = dwell_q;
        mask_d  = mask_q;
        adv     = 1'b0;
        go_idle = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && !stop_i && (line_mask_i != 4'b0000)) begin
                    state_d = ACTIVE;
                    dwell_d = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
                    mask_d  = line_mask_i;
                    idx_d   = lowest(line_mask_i);
                    cnt_d   = '0;
                end
            end
            ACTIVE: begin
                if (stop_i) begin
                    go_idle = 1'b1;
                end else if (cnt_q == dwell_q - DWELL_W'(1)) begin
                    if (BLANK_CYCLES > 0) begin
                        state_d = BLANK;
                        bcnt_d  = '0;
                    end else begin
                        adv = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            BLANK: begin
                if (stop_i) begin
                    go_idle = 1'b1;
                end else if (bcnt_q == BLAST) begin
                    adv = 1'b1;
                end else begin
                    bcnt_d = bcnt_q + BW'(1);
                end
            end
            default: go_idle = 1'b1;
        endcase

        // mode_cont is only consulted here, at the wrap point of a scan
        if (adv) begin
            cnt_d = '0;
            if (has_above(mask_q, idx_q)) begin
                idx_d   = next_above(mask_q, idx_q);
                state_d = ACTIVE;
            end else if (mode_cont_i) begin
                idx_d   = lowest(mask_q);
                state_d = ACTIVE;
            end else begin
                go_idle = 1'b1;
            end
        end
        if (go_idle) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            cnt_d   = '0;
            bcnt_d  = '0;
        end

        // outputs are precomputed from next state so that they leave flops
        sel_d      = (state_d == IDLE) ? 2'b00 : idx_d;
        en_d       = (state_d == ACTIVE) ? EN_ON : EN_OFF;
        busy_d     = (state_d != IDLE);
        ld_d       = (state_d == ACTIVE) && (cnt_d == dwell_d - DWELL_W'(1));
        last_cycle = (BLANK_CYCLES > 0) ? ((state_d == BLANK) && (bcnt_d == BLAST)) : ld_d;
        sd_d       = last_cycle && !has_above(mask_d, idx_d);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            dwell_q <= '0;
            mask_q  <= 4'b0000;
            sel_q   <= 2'b00;
            en_q    <= EN_OFF;
            busy_q  <= 1'b0;
            ld_q    <= 1'b0;
            sd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            dwell_q <= dwell_d;
            mask_q  <= mask_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            ld_q    <= ld_d;
            sd_q    <= sd_d;
        end
    end

    assign sel_a_o     = sel_q[1];
    assign sel_b_o     = sel_q[0];
    assign dec_en_o    = en_q;
    assign busy_o      = busy_q;
    assign line_done_o = ld_q;
    assign scan_done_o = sd_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Bench for decoder_scan_sequencer: three builds (blank=1 high-enable, blank=1 low-enable, blank=0) share one stimulus stream.
module tb_decoder_scan_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, stop, mode_cont;
    logic [7:0] dwell;
    logic [3:0] line_mask;
    logic       sa[3], sb[3], en[3], bz[3], ld[3], sd[3];

    int total = 0;
    int bad   = 0;

    decoder_scan_sequencer #(.DWELL_W(8), .BLANK_CYCLES(1), .EN_ACT_HIGH(1'b1)) u0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .mode_cont_i(mode_cont),
        .dwell_i(dwell), .line_mask_i(line_mask), .sel_a_o(sa[0]), .sel_b_o(sb[0]),
        .dec_en_o(en[0]), .busy_o(bz[0]), .line_done_o(ld[0]), .scan_done_o(sd[0]));
    decoder_scan_sequencer #(.DWELL_W(8), .BLANK_CYCLES(1), .EN_ACT_HIGH(1'b0)) u1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .mode_cont_i(mode_cont),
        .dwell_i(dwell), .line_mask_i(line_mask), .sel_a_o(sa[1]), .sel_b_o(sb[1]),
        .dec_en_o(en[1]), .busy_o(bz[1]), .line_done_o(ld[1]), .scan_done_o(sd[1]));
    decoder_scan_sequencer #(.DWELL_W(8), .BLANK_CYCLES(0), .EN_ACT_HIGH(1'b1)) u2 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .mode_cont_i(mode_cont),
        .dwell_i(dwell), .line_mask_i(line_mask), .sel_a_o(sa[2]), .sel_b_o(sb[2]),
        .dec_en_o(en[2]), .busy_o(bz[2]), .line_done_o(ld[2]), .scan_done_o(sd[2]));

    // Reference: a scan is a list of enabled lines, each occupying dwell+blank cycles.
    int         blank_of[3] = '{1, 1, 0};
    bit         m_busy[3];
    int         m_pos[3], m_t[3], m_dw[3];
    logic [3:0] m_mask[3];

    function automatic int nlines(input logic [3:0] m);
        nlines = 0;
        for (int j = 0; j < 4; j++) if (m[j]) nlines++;
    endfunction

    function automatic int nth_line(input logic [3:0] m, input int p);
        int seen;
        seen = 0;
        nth_line = 0;
        for (int j = 0; j < 4; j++) begin
            if (m[j]) begin
                if (seen == p) nth_line = j;
                seen++;
            end
        end
    endfunction

    function automatic logic [5:0] expv(input int k);
        int line, per;
        logic [1:0] l2;
        if (!m_busy[k]) return 6'b0;
        line = nth_line(m_mask[k], m_pos[k]);
        l2   = 2'(line);
        per  = m_dw[k] + blank_of[k];
        return {l2, (m_t[k] < m_dw[k]), 1'b1, (m_t[k] == m_dw[k] - 1),
                ((m_t[k] == per - 1) && (m_pos[k] == nlines(m_mask[k]) - 1))};
    endfunction

    function automatic logic [5:0] obsv(input int k);
        logic e;
        e = (k == 1) ? ~en[k] : en[k];
        return {sa[k], sb[k], e, bz[k], ld[k], sd[k]};
    endfunction

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_busy[k] = 1'b0;
            end else if (!m_busy[k]) begin
                if (start && !stop && line_mask != 4'b0000) begin
                    m_busy[k] = 1'b1;
                    m_mask[k] = line_mask;
                    m_dw[k]   = (dwell == 8'd0) ? 1 : int'(dwell);
                    m_pos[k]  = 0;
                    m_t[k]    = 0;
                end
            end else if (stop) begin
                m_busy[k] = 1'b0;
            end else if (m_t[k] == m_dw[k] + blank_of[k] - 1) begin
                m_t[k] = 0;
                if (m_pos[k] == nlines(m_mask[k]) - 1) begin
                    if (mode_cont) m_pos[k] = 0;
                    else m_busy[k] = 1'b0;
                end else begin
                    m_pos[k]++;
                end
            end else begin
                m_t[k]++;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic go_idle();
        stop = 1'b1; start = 1'b0;
        cyc();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        dwell = 8'd3; line_mask = 4'b1111; mode_cont = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int c = 0; c < 5; c++) cyc();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            cyc();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obsv(k) !== expv(k)) begin
                    bad++;
                    $display("FAIL reset dut%0d c=%0d got=%b want=%b", k, c, obsv(k), expv(k));
                end
            end
        end
        total++;
        if ({sa[0], sb[0], en[0], bz[0], ld[0], sd[0]} !== 6'b0) begin
            bad++;
            $display("FAIL reset_vals got=%b want=000000", {sa[0], sb[0], en[0], bz[0], ld[0], sd[0]});
        end
        total++;
        if (en[1] !== 1'b1) begin
            bad++;
            $display("FAIL reset_en_low got=%b want=1", en[1]);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_scan();
        int sd_at[3], off_at[3];
        sd_at = '{-1, -1, -1}; off_at = '{-1, -1, -1};
        dwell = 8'd2; line_mask = 4'b1111; mode_cont = 1'b0; start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            cyc();
            start = 1'b0;
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obsv(k) !== expv(k)) begin
                    bad++;
                    $display("FAIL single_scan dut%0d c=%0d got=%b want=%b", k, c, obsv(k), expv(k));
                end
                if (sd[k] === 1'b1 && sd_at[k] < 0) sd_at[k] = c;
                if (bz[k] === 1'b0 && off_at[k] < 0) off_at[k] = c;
            end
        end
        total++;
        if (sd_at[0] != 12 || off_at[0] != 13) begin
            bad++;
            $display("FAIL single_scan_timing scan_done@%0d busy_off@%0d want 12 13", sd_at[0], off_at[0]);
        end
        total++;
        if (sd_at[2] != 8 || off_at[2] != 9) begin
            bad++;
            $display("FAIL noblank_dwell2_timing scan_done@%0d busy_off@%0d want 8 9", sd_at[2], off_at[2]);
        end
    endtask

    task automatic test_noblank();
        int en_cnt, sd_at;
        en_cnt = 0; sd_at = -1;
        dwell = 8'd3; line_mask = 4'b1111; mode_cont = 1'b0; start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            cyc();
            start = 1'b0;
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obsv(k) !== expv(k)) begin
                    bad++;
                    $display("FAIL noblank dut%0d c=%0d got=%b want=%b", k, c, obsv(k), expv(k));
                end
            end
            if (en[2] === 1'b1) en_cnt++;
            if (sd[2] === 1'b1 && ld[2] === 1'b1 && sd_at < 0) sd_at = c;
        end
        total++;
        if (en_cnt != 12 || sd_at != 12) begin
            bad++;
            $display("FAIL noblank_en en_cycles=%0d scan_done@%0d want 12 12", en_cnt, sd_at);
        end
    endtask

    task automatic test_cont();
        bit dropped;
        dropped = 1'b0;
        dwell = 8'd1; line_mask = 4'b1010; mode_cont = 1'b1; start = 1'b1;
        for (int c = 1; c <= 60 && !dropped; c++) begin
            cyc();
            start = 1'b0;
            if (c == 14) mode_cont = 1'b0;
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obsv(k) !== expv(k)) begin
                    bad++;
                    $display("FAIL cont dut%0d c=%0d got=%b want=%b", k, c, obsv(k), expv(k));
                end
            end
            if (c > 14 && bz[0] === 1'b0 && bz[2] === 1'b0) dropped = 1'b1;
        end
        total++;
        if (!dropped) begin
            bad++;
            $display("FAIL cont_drop busy=%b want 0 within budget", bz[0]);
        end
    endtask

    task automatic test_stop();
        dwell = 8'd3; line_mask = 4'b1111; mode_cont = 1'b1; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            start = 1'b0;
            stop = (c == 6);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obsv(k) !== expv(k)) begin
                    bad++;
                    $display("FAIL stop dut%0d c=%0d got=%b want=%b", k, c, obsv(k), expv(k));
                end
            end
        end
        stop = 1'b0;
        total++;
        if (bz[0] !== 1'b0 || en[0] !== 1'b0) begin
            bad++;
            $display("FAIL stop_idle busy=%b en=%b want 0 0", bz[0], en[0]);
        end
        line_mask = 4'b0000; start = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cyc();
            total++;
            if (bz[0] !== 1'b0 || bz[2] !== 1'b0) begin
                bad++;
                $display("FAIL mask0_start busy=%b%b want 00", bz[0], bz[2]);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_dwell_zero();
        int off_at;
        off_at = -1;
        dwell = 8'd0; line_mask = 4'b1111; mode_cont = 1'b0; start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            if (c == 1) line_mask = 4'b0001;
            if (c == 4) start = 1'b0;
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obsv(k) !== expv(k)) begin
                    bad++;
                    $display("FAIL dwell_zero dut%0d c=%0d got=%b want=%b", k, c, obsv(k), expv(k));
                end
            end
            if (bz[0] === 1'b0 && off_at < 0) off_at = c;
        end
        total++;
        if (off_at != 9) begin
            bad++;
            $display("FAIL dwell_zero_len busy_off@%0d want 9", off_at);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            start     = ($urandom_range(0, 5) == 0);
            stop      = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 15) == 0) mode_cont = ~mode_cont;
            dwell     = 8'($urandom_range(0, 4));
            line_mask = 4'($urandom_range(0, 15));
            cyc();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obsv(k) !== expv(k)) begin
                    bad++;
                    $display("FAIL random dut%0d c=%0d got=%b want=%b", k, c, obsv(k), expv(k));
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; mode_cont = 1'b0;
        dwell = 8'd0; line_mask = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            m_busy[k] = 1'b0; m_pos[k] = 0; m_t[k] = 0; m_dw[k] = 1; m_mask[k] = 4'b0000;
        end
        cyc();
        cyc();
        rst = 1'b0;
        test_reset();
        test_single_scan();
        go_idle();
        test_noblank();
        go_idle();
        test_cont();
        go_idle();
        test_stop();
        go_idle();
        test_dwell_zero();
        go_idle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
